set_bit_scan: RTL and testbench

SET_BIT_SCAN -- requirements
Module: set_bit_scan

---
 rtl/set_bit_scan.sv | 116 +++++++++++
 tb/tb_set_bit_scan.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/set_bit_scan.sv
// Set-bit scanner: accepts a vector, then emits the index of every set bit one per
// handshake, most- or least-significant first, with backpressure, flush and zero detect.
module set_bit_scan #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int IDXW     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic [WIDTH-1:0] i_vector,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [IDXW-1:0]  o_index,
  output logic             o_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_zero,
  input  logic             i_flush
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] residue_q, residue_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             zero_q, zero_d;
  logic [IDXW-1:0]  idx_s;
  logic             last_s;
  logic [WIDTH-1:0] sel_mask_s;

  // Priority pick of the next set bit; later loop iterations win
  always_comb begin
    idx_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST) begin
        idx_s = residue_q[i] ? IDXW'(i) : idx_s;
      end else begin
        idx_s = residue_q[WIDTH-1-i] ? IDXW'(WIDTH-1-i) : idx_s;
      end
    end
  end

  // Single-set-bit detect and one-hot of the bit being emitted
  always_comb begin
    last_s     = (residue_q != '0) && ((residue_q & (residue_q - WIDTH'(1))) == '0);
    sel_mask_s = WIDTH'(1) << idx_s;
  end

  // Next-state logic; flush overrides every transfer
  always_comb begin
    state_d   = state_q;
    residue_d = residue_q;
    zero_d    = 1'b0;
    if (i_flush) begin
      state_d   = IDLE;
      residue_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid && ready_q) begin
            if (i_vector == '0) begin
              zero_d = 1'b1;
            end else begin
              residue_d = i_vector;
              state_d   = SCAN;
            end
          end else begin
            state_d = IDLE;
          end
        end
        SCAN: begin
          if (i_ready) begin
            residue_d = residue_q & ~sel_mask_s;
            state_d   = last_s ? IDLE : SCAN;
          end else begin
            state_d = SCAN;
          end
        end
        default: begin
          state_d   = IDLE;
          residue_d = '0;
        end
      endcase
    end
    ready_d = (state_d == IDLE);
    valid_d = (state_d == SCAN);
  end

  // State, residue and registered handshake flags
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q   <= IDLE;
      residue_q <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      residue_q <= residue_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      zero_q    <= zero_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_zero  = zero_q;
  assign o_index = idx_s;
  assign o_last  = last_s;

endmodule

// File: tb/tb_set_bit_scan.sv
// Randomized self-checking bench: an MSB-first and an LSB-first instance share stimulus
// and are compared each cycle against queues of expected indices.
module tb_set_bit_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] vec = 8'h00;
  logic       vld = 1'b0;
  logic       rdy = 1'b1;
  logic       flush = 1'b0;

  logic       m_ready, m_valid, m_last, m_zero;
  logic [2:0] m_idx;
  logic       l_ready, l_valid, l_last, l_zero;
  logic [2:0] l_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  set_bit_scan #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .i_clk(clk), .i_arst_n(rst_n), .i_vector(vec), .i_valid(vld), .o_ready(m_ready),
    .o_index(m_idx), .o_last(m_last), .o_valid(m_valid), .i_ready(rdy), .o_zero(m_zero),
    .i_flush(flush));

  set_bit_scan #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .i_clk(clk), .i_arst_n(rst_n), .i_vector(vec), .i_valid(vld), .o_ready(l_ready),
    .o_index(l_idx), .o_last(l_last), .o_valid(l_valid), .i_ready(rdy), .o_zero(l_zero),
    .i_flush(flush));

  task automatic test_reset();
    #3;
    checks++;
    if ({m_ready, m_valid, m_last, m_zero, m_idx, l_ready, l_valid, l_last, l_zero, l_idx} !== 14'b0) begin
      errors++;
      $display("FAIL reset_outputs got m=%b%b%b%b/%0d l=%b%b%b%b/%0d want all zero",
               m_ready, m_valid, m_last, m_zero, m_idx, l_ready, l_valid, l_last, l_zero, l_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (m_ready !== 1'b0 || l_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge got %b/%b want 0", m_ready, l_ready);
    end
    @(negedge clk);
    checks++;
    if (m_ready !== 1'b1 || l_ready !== 1'b1 || m_valid !== 1'b0 || l_valid !== 1'b0) begin
      errors++; $display("FAIL ready_after_release got rdy %b/%b vld %b/%b want 1/1 0/0",
                         m_ready, l_ready, m_valid, l_valid);
    end
  endtask

  task automatic test_scan();
    logic [7:0] vecs[$];
    int qm[$];
    int ql[$];
    int cyc;
    logic r;
    logic [7:0] v;
    vecs = '{8'hA4, 8'h80, 8'h00, 8'h01, 8'hFF};
    for (int i = 0; i < 40; i++) vecs.push_back(8'($urandom));
    foreach (vecs[n]) begin
      v = vecs[n];
      qm.delete(); ql.delete();
      for (int b = 7; b >= 0; b--) if (v[b]) qm.push_back(b);
      for (int b = 0; b < 8; b++) if (v[b]) ql.push_back(b);
      checks++;
      if (m_ready !== 1'b1 || l_ready !== 1'b1) begin
        errors++; $display("FAIL scan_ready_idle vec=%h got %b/%b want 1", v, m_ready, l_ready);
      end
      vld = 1'b1; vec = v; rdy = 1'b1;
      @(negedge clk);
      vld = 1'b0;
      if (qm.size() == 0) begin
        checks++;
        if (m_zero !== 1'b1 || l_zero !== 1'b1 || m_valid !== 1'b0 || l_valid !== 1'b0 || m_ready !== 1'b1) begin
          errors++; $display("FAIL zero_pulse got zero %b/%b vld %b/%b rdy %b want 1/1 0/0 1",
                             m_zero, l_zero, m_valid, l_valid, m_ready);
        end
        @(negedge clk);
        checks++;
        if (m_zero !== 1'b0 || l_zero !== 1'b0 || m_valid !== 1'b0 || m_ready !== 1'b1) begin
          errors++; $display("FAIL zero_single_cycle got zero %b/%b vld %b rdy %b want 0/0 0 1",
                             m_zero, l_zero, m_valid, m_ready);
        end
      end else begin
        cyc = 0;
        while (qm.size() > 0 && cyc < 64) begin
          checks++;
          if (m_valid !== 1'b1 || m_ready !== 1'b0 || int'(m_idx) !== qm[0] || m_last !== (qm.size() == 1)) begin
            errors++; $display("FAIL scan_msb vec=%h got v%b r%b idx %0d last %b want v1 r0 idx %0d last %b",
                               v, m_valid, m_ready, m_idx, m_last, qm[0], qm.size() == 1);
          end
          checks++;
          if (l_valid !== 1'b1 || int'(l_idx) !== ql[0] || l_last !== (ql.size() == 1)) begin
            errors++; $display("FAIL scan_lsb vec=%h got v%b idx %0d last %b want v1 idx %0d last %b",
                               v, l_valid, l_idx, l_last, ql[0], ql.size() == 1);
          end
          r = (n < 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
          rdy = r; vld = 1'($urandom_range(0, 1)); vec = 8'($urandom);
          @(negedge clk);
          cyc++;
          if (r) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
          end
        end
        vld = 1'b0; rdy = 1'b1;
        checks++;
        if (qm.size() != 0) begin
          errors++; $display("FAIL scan_timeout vec=%h remaining %0d want 0", v, qm.size());
        end
        checks++;
        if (m_valid !== 1'b0 || l_valid !== 1'b0 || m_ready !== 1'b1 || l_ready !== 1'b1) begin
          errors++; $display("FAIL scan_end vec=%h got vld %b/%b rdy %b/%b want 0/0 1/1",
                             v, m_valid, l_valid, m_ready, l_ready);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    vld = 1'b1; vec = 8'hFF; rdy = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (m_valid !== 1'b1 || m_idx !== 3'd7 || m_last !== 1'b0 || l_idx !== 3'd0) begin
        errors++; $display("FAIL bp_hold cyc %0d got v%b idx %0d/%0d last %b want v1 idx 7/0 last 0",
                           k, m_valid, m_idx, l_idx, m_last);
      end
      rdy = 1'b0;
      @(negedge clk);
    end
    rdy = 1'b1;
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (m_valid !== 1'b1 || int'(m_idx) !== 7 - j || int'(l_idx) !== j || m_last !== (j == 7)) begin
        errors++; $display("FAIL bp_drain n %0d got v%b idx %0d/%0d last %b want v1 idx %0d/%0d last %b",
                           j, m_valid, m_idx, l_idx, m_last, 7 - j, j, j == 7);
      end
      @(negedge clk);
    end
    checks++;
    if (m_valid !== 1'b0 || m_ready !== 1'b1) begin
      errors++; $display("FAIL bp_end got vld %b rdy %b want 0 1", m_valid, m_ready);
    end
  endtask

  task automatic test_flush();
    vld = 1'b1; vec = 8'h61; rdy = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_idx !== 3'd6 || l_idx !== 3'd0) begin
      errors++; $display("FAIL flush_first got v%b idx %0d/%0d want v1 idx 6/0", m_valid, m_idx, l_idx);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || l_valid !== 1'b0 || m_ready !== 1'b1 || l_ready !== 1'b1) begin
      errors++; $display("FAIL flush_abort got vld %b/%b rdy %b/%b want 0/0 1/1",
                         m_valid, l_valid, m_ready, l_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || l_valid !== 1'b0) begin
        errors++; $display("FAIL flush_stale cyc %0d got vld %b/%b want 0", k, m_valid, l_valid);
      end
    end
    vld = 1'b1; vec = 8'h00; flush = 1'b1;
    @(negedge clk);
    checks++;
    if (m_zero !== 1'b0 || l_zero !== 1'b0 || m_valid !== 1'b0 || m_ready !== 1'b1) begin
      errors++; $display("FAIL flush_idle_zero got zero %b/%b vld %b rdy %b want 0/0 0 1",
                         m_zero, l_zero, m_valid, m_ready);
    end
    vec = 8'h12;
    @(negedge clk);
    vld = 1'b0; flush = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || l_valid !== 1'b0 || m_ready !== 1'b1) begin
      errors++; $display("FAIL flush_idle_block got vld %b/%b rdy %b want 0/0 1", m_valid, l_valid, m_ready);
    end
  endtask

  task automatic test_async_reset();
    vld = 1'b1; vec = 8'hF0; rdy = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_ready, m_valid, m_last, m_zero, m_idx, l_ready, l_valid, l_last, l_zero, l_idx} !== 14'b0) begin
      errors++; $display("FAIL arst_immediate got m=%b%b%b%b/%0d l=%b%b%b%b/%0d want all zero",
                         m_ready, m_valid, m_last, m_zero, m_idx, l_ready, l_valid, l_last, l_zero, l_idx);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (m_ready !== 1'b1 || l_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL arst_release got rdy %b/%b vld %b want 1/1 0", m_ready, l_ready, m_valid);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || l_valid !== 1'b0) begin
        errors++; $display("FAIL arst_stale cyc %0d got vld %b/%b want 0", k, m_valid, l_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
